l2cache_control: RTL and testbench



---
 rtl/l2cache_control.sv | 214 +++++++++++++++++++++
 tb/tb_l2cache_control.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/l2cache_control.sv
// ---------------------------------------------------------------------------
// l2cache_control
//
// Control FSM for the 2-way set-associative L2 cache. Sequences L1 requests
// through tag check, dirty-victim writeback and line fill, and is the only
// driver of the tag/valid/dirty/LRU/data array strobes and of the pmem
// request lines. All outputs are decoded combinationally from the state
// register and the current inputs.
//
// Optional feature macro: L2_PERF_COUNTERS_EN adds saturating hit/miss
// counters (hit_count, miss_count). Without it those ports do not exist and
// the FSM is unchanged.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   mem_read, mem_write L1 request, held until mem_resp (both high = write)
//   mem_resp            one-cycle completion pulse to L1
//   hit, hit_way        combinational tag compare result from the datapath
//   lru_way             LRU array output, i.e. the victim way
//   victim_dirty        dirty bit of lru_way in the indexed set
//   pmem_read/write     line read/write request to memory
//   pmem_resp           memory completion pulse
//   tag_load, valid_load, dirty_load, dirty_in, lru_load, lru_in,
//   data_we, data_sel, addr_sel   array and datapath controls
//   hit_count, miss_count         perf counters (L2_PERF_COUNTERS_EN only)
//   state_dbg           current FSM state, for observation only
//
// Handshakes: an L1 request (mem_read/mem_write) is "valid" and stays high
// until the cycle mem_resp pulses, which acts as the one-cycle "ready"; the
// transfer completes in that cycle and L1 drops the request on the next edge.
// A pmem request (pmem_read/pmem_write) is held high up to and including the
// cycle in which pmem_resp is sampled; pmem_resp completes it in that cycle.
// ---------------------------------------------------------------------------
module l2cache_control #(
    parameter int s_index = 3,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_read,
    input  logic             mem_write,
    output logic             mem_resp,
    input  logic             hit,
    input  logic             hit_way,
    input  logic             lru_way,
    input  logic             victim_dirty,
    output logic             pmem_read,
    output logic             pmem_write,
    input  logic             pmem_resp,
    output logic [1:0]       tag_load,
    output logic [1:0]       valid_load,
    output logic [1:0]       dirty_load,
    output logic             dirty_in,
    output logic             lru_load,
    output logic             lru_in,
    output logic [1:0]       data_we,
    output logic             data_sel,
    output logic             addr_sel,
`ifdef L2_PERF_COUNTERS_EN
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count,
`endif
    output logic [1:0]       state_dbg
);

    // The set index itself never passes through this block; the parameter
    // exists so the controller is configured alongside the arrays it drives.
    if (s_index < 1) begin : g_bad_index
        $error("l2cache_control: s_index must be at least 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt
        $error("l2cache_control: CNT_W must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CHECK     = 2'd1,
        WRITEBACK = 2'd2,
        FILL      = 2'd3
    } state_t;

    state_t state, state_n;
    logic   filled;
    logic   req;
    logic   hit_oh_sel;

    assign req       = mem_read | mem_write;
    assign state_dbg = state;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // ---------------- next state / outputs ----------------
    always_comb begin
        state_n    = state;
        mem_resp   = 1'b0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        tag_load   = 2'b00;
        valid_load = 2'b00;
        dirty_load = 2'b00;
        dirty_in   = 1'b0;
        lru_load   = 1'b0;
        lru_in     = 1'b0;
        data_we    = 2'b00;
        data_sel   = 1'b0;
        addr_sel   = 1'b0;
        hit_oh_sel = hit_way;

        case (state)
            IDLE: begin
                if (req) begin
                    state_n = CHECK;
                end
            end

            CHECK: begin
                if (!req) begin
                    // Request withdrawn (e.g. during a miss): finish silently.
                    state_n = IDLE;
                end else if (hit) begin
                    mem_resp = 1'b1;
                    lru_load = 1'b1;
                    lru_in   = ~hit_way;
                    // Write wins when both request lines are high.
                    if (mem_write) begin
                        data_we    = hit_oh_sel ? 2'b10 : 2'b01;
                        dirty_load = hit_oh_sel ? 2'b10 : 2'b01;
                        dirty_in   = 1'b1;
                        data_sel   = 1'b0;
                    end
                    state_n = IDLE;
                end else begin
                    state_n = victim_dirty ? WRITEBACK : FILL;
                end
            end

            WRITEBACK: begin
                pmem_write = 1'b1;
                addr_sel   = 1'b1;
                if (pmem_resp) begin
                    state_n = FILL;
                end
            end

            FILL: begin
                pmem_read = 1'b1;
                addr_sel  = 1'b0;
                if (pmem_resp) begin
                    // The returning line lands in the victim way in the
                    // same cycle the response is seen; it is installed clean.
                    data_we    = lru_way ? 2'b10 : 2'b01;
                    tag_load   = lru_way ? 2'b10 : 2'b01;
                    valid_load = lru_way ? 2'b10 : 2'b01;
                    dirty_load = lru_way ? 2'b10 : 2'b01;
                    dirty_in   = 1'b0;
                    data_sel   = 1'b1;
                    state_n    = CHECK;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // ---------------- filled flag ----------------
    // Marks that the current CHECK is the re-check after a fill, so the
    // resulting hit is not counted as a genuine hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filled <= 1'b0;
        end else if (state_n == IDLE) begin
            filled <= 1'b0;
        end else if (state == FILL && pmem_resp) begin
            filled <= 1'b1;
        end
    end

`ifdef L2_PERF_COUNTERS_EN
    // ---------------- performance counters ----------------
    logic hit_inc;
    logic miss_inc;

    assign hit_inc  = (state == CHECK) && req && hit && !filled;
    assign miss_inc = (state == CHECK) && req && !hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit_inc && (hit_count != {CNT_W{1'b1}})) begin
                hit_count <= hit_count + 1'b1;
            end
            if (miss_inc && (miss_count != {CNT_W{1'b1}})) begin
                miss_count <= miss_count + 1'b1;
            end
        end
    end
`else
    // filled only feeds the counters; keep it observed in the lean build.
    logic filled_unused;
    assign filled_unused = filled;
`endif

endmodule

// File: tb/tb_l2cache_control.sv
// ---------------------------------------------------------------------------
// tb_l2cache_control
//
// Drives L1 transactions into l2cache_control and checks every cycle of
// every transaction against a timeline model: for each transaction the bench
// works out, from the hit/miss/dirty choice and the memory response cycles,
// which cycles are writeback, which are fill, where the array writes land and
// where mem_resp must appear, then compares all outputs against that.
// ---------------------------------------------------------------------------
module tb_l2cache_control;

`ifdef L2_PERF_COUNTERS_EN
    localparam int CNT_W = 4;
`else
    localparam int CNT_W = 32;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic       mem_read = 1'b0, mem_write = 1'b0, mem_resp;
    logic       hit = 1'b0, hit_way = 1'b0, lru_way = 1'b0, victim_dirty = 1'b0;
    logic       pmem_read, pmem_write, pmem_resp = 1'b0;
    logic [1:0] tag_load, valid_load, dirty_load, data_we;
    logic       dirty_in, lru_load, lru_in, data_sel, addr_sel;
    logic [1:0] state_dbg;
`ifdef L2_PERF_COUNTERS_EN
    logic [CNT_W-1:0] hit_count, miss_count;
`endif

    l2cache_control #(.s_index(3), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
        .hit(hit), .hit_way(hit_way), .lru_way(lru_way), .victim_dirty(victim_dirty),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
        .tag_load(tag_load), .valid_load(valid_load), .dirty_load(dirty_load),
        .dirty_in(dirty_in), .lru_load(lru_load), .lru_in(lru_in),
        .data_we(data_we), .data_sel(data_sel), .addr_sel(addr_sel),
`ifdef L2_PERF_COUNTERS_EN
        .hit_count(hit_count), .miss_count(miss_count),
`endif
        .state_dbg(state_dbg)
    );

    // Output bundle: {mem_resp, pmem_read, pmem_write, addr_sel, data_sel,
    //                 dirty_in, lru_load, lru_in, tag_load, valid_load,
    //                 dirty_load, data_we}
    logic [15:0] obs_v;
    assign obs_v = {mem_resp, pmem_read, pmem_write, addr_sel, data_sel,
                    dirty_in, lru_load, lru_in, tag_load, valid_load,
                    dirty_load, data_we};

    int n_checks = 0;
    int n_pass   = 0;

`ifdef L2_PERF_COUNTERS_EN
    int hit_m  = 0;
    int miss_m = 0;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`endif

    // ---------------- scoreboard compare ----------------
    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    function automatic logic [1:0] oh(input bit w);
        return w ? 2'b10 : 2'b01;
    endfunction

    // ---------------- transaction driver + timeline model ----------------
    // Cycle 0 is the cycle the request is first presented in IDLE.
    // hit txn       : mem_resp at 1
    // clean miss    : fill cycles 2..fill_end, array writes at fill_end, resp at fill_end+1
    // dirty miss    : writeback 2..wb_end, fill wb_end+1..fill_end, resp at fill_end+1
    // drop_at       : first cycle with the request withdrawn (large = never)
    // rst_at        : cycle at which reset is pulsed mid-transaction (-1 = never)
    task automatic run_txn(input bit rd, input bit wr, input bit is_hit,
                           input bit hw, input bit lw, input bit vd,
                           input int wb_end, input int fill_end,
                           input int drop_at, input int rst_at, input string name);
        int r, fs;
        bit eff;
        r   = is_hit ? 1 : fill_end + 1;
        fs  = vd ? wb_end + 1 : 2;
        eff = is_hit ? hw : lw;
`ifdef L2_PERF_COUNTERS_EN
        if (drop_at > 1) begin
            if (is_hit) hit_m  = (hit_m  < CNT_MAX) ? hit_m + 1  : CNT_MAX;
            else        miss_m = (miss_m < CNT_MAX) ? miss_m + 1 : CNT_MAX;
        end
`endif
        for (int c = 0; c <= r + 1; c++) begin
            bit req, wbc, flc, fe, rc;
            logic [15:0] e;
            logic [1:0]  e_tag, e_val, e_dl, e_we;
            logic        e_di;
            req = (c < drop_at) && (c <= r);
            wbc = !is_hit && vd && (c >= 2) && (c <= wb_end);
            flc = !is_hit && (c >= fs) && (c <= fill_end);
            fe  = !is_hit && (c == fill_end);
            rc  = (c == r) && req;

            mem_read     = req & rd;
            mem_write    = req & wr;
            hit          = is_hit ? 1'b1 : (c == r);
            hit_way      = (is_hit || c == r) ? eff : 1'($urandom_range(0, 1));
            lru_way      = lw;
            victim_dirty = vd;
            if (wbc)      pmem_resp = (c == wb_end);
            else if (flc) pmem_resp = fe;
            else          pmem_resp = 1'($urandom_range(0, 1));

            e_tag = fe ? oh(lw) : 2'b00;
            e_val = fe ? oh(lw) : 2'b00;
            e_dl  = fe ? oh(lw) : ((rc && wr) ? oh(eff) : 2'b00);
            e_we  = fe ? oh(lw) : ((rc && wr) ? oh(eff) : 2'b00);
            e_di  = rc && wr;
            e = {rc, flc, wbc, wbc, fe, e_di, rc, rc & ~eff, e_tag, e_val, e_dl, e_we};

            @(negedge clk);
            check16($sformatf("%s c%0d", name, c), obs_v, e);

            if (c == rst_at) begin
                rst_n = 1'b0;
                #1;
                check16($sformatf("%s pmem_read_in_reset", name), {15'd0, pmem_read}, 16'd0);
                check16($sformatf("%s outputs_in_reset", name), obs_v, 16'd0);
`ifdef L2_PERF_COUNTERS_EN
                hit_m  = 0;
                miss_m = 0;
                check16($sformatf("%s counters_in_reset", name),
                        16'({hit_count, miss_count}), 16'd0);
`endif
                @(posedge clk); #1;
                mem_read  = 1'b0;
                mem_write = 1'b0;
                pmem_resp = 1'b0;
                rst_n     = 1'b1;
                return;
            end

`ifdef L2_PERF_COUNTERS_EN
            if (c == r + 1) begin
                check16($sformatf("%s hit_count", name), 16'(hit_count), 16'(hit_m));
                check16($sformatf("%s miss_count", name), 16'(miss_count), 16'(miss_m));
            end
`endif
            @(posedge clk); #1;
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        pmem_resp = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int NEVER;
        NEVER = 1000;

        // Reset: outputs are all zero while held.
        rst_n = 1'b0;
        mem_read = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check16("reset_outputs", obs_v, 16'd0);
`ifdef L2_PERF_COUNTERS_EN
        check16("reset_counters", 16'({hit_count, miss_count}), 16'd0);
`endif
        mem_read = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Read hit on way 1, write hit on way 0.
        run_txn(1, 0, 1, 1, 0, 0, 0, 0, NEVER, -1, "read_hit_w1");
        run_txn(0, 1, 1, 0, 1, 0, 0, 0, NEVER, -1, "write_hit_w0");
        // Both request lines high behaves as a write.
        run_txn(1, 1, 1, 1, 0, 0, 0, 0, NEVER, -1, "rdwr_hit_w1");
        // Clean miss, victim way 1, fill response at cycle 6.
        run_txn(1, 0, 0, 0, 1, 0, 0, 6, NEVER, -1, "clean_miss");
        // Dirty miss: writeback response at 5, fill response at 9.
        run_txn(0, 1, 0, 0, 0, 1, 5, 9, NEVER, -1, "dirty_miss");
        // Reset mid-fill, then a hit proves the FSM came back to IDLE.
        run_txn(1, 0, 0, 0, 1, 1, 3, 8, NEVER, 5, "reset_in_fill");
        run_txn(1, 0, 1, 0, 0, 0, 0, 0, NEVER, -1, "hit_after_reset");
        // Request withdrawn during fill: fill completes, no response.
        run_txn(1, 0, 0, 0, 0, 0, 0, 6, 4, -1, "drop_in_fill");
        // Request withdrawn during writeback: transfer still runs to the end.
        run_txn(0, 1, 0, 0, 1, 1, 4, 6, 3, -1, "drop_in_wb");
        // Zero-wait memory responses.
        run_txn(1, 0, 0, 0, 0, 1, 2, 3, NEVER, -1, "dirty_fast");
        run_txn(0, 1, 0, 0, 1, 0, 0, 2, NEVER, -1, "clean_fast");

        // Randomized transactions.
        for (int i = 0; i < 40; i++) begin
            bit rd, wr, ih, hw, lw, vd;
            int wb_end, fs, fill_end, r, drop;
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            if (!rd && !wr) rd = 1'b1;
            ih = 1'($urandom_range(0, 1));
            hw = 1'($urandom_range(0, 1));
            lw = 1'($urandom_range(0, 1));
            vd = 1'($urandom_range(0, 1));
            wb_end   = 2 + $urandom_range(0, 3);
            fs       = vd ? wb_end + 1 : 2;
            fill_end = fs + $urandom_range(0, 4);
            r        = fill_end + 1;
            drop     = NEVER;
            if (!ih && ($urandom_range(0, 4) == 0)) drop = $urandom_range(2, r);
            run_txn(rd, wr, ih, hw, lw, vd, wb_end, fill_end, drop, -1,
                    $sformatf("rand%0d", i));
        end

        // Twenty back-to-back hits: the narrow hit counter must saturate.
        for (int i = 0; i < 20; i++) begin
            run_txn(1, 0, 1, 1'($urandom_range(0, 1)), 0, 0, 0, 0, NEVER, -1,
                    $sformatf("sat_hit%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
